// File: rtl/moving_avg_filter_if.sv
// rtl/moving_avg_filter_if.sv - sample stream bundle for the moving-average filter
// master drives samples and observes averages; slave is the filter side.
interface moving_avg_filter_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              window_full;

   modport master (
      output in_valid,
      output in_data,
      input  out_valid,
      input  out_data,
      input  window_full
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output out_valid,
      output out_data,
      output window_full
   );
endinterface

// File: rtl/moving_avg_filter.sv
// rtl/moving_avg_filter.sv - running-sum boxcar average over the last 2**LOG2_DEPTH samples
// Define MOVING_AVG_ROUND_EN for round-half-up output instead of truncation.
module moving_avg_filter #(
   parameter int DATA_W     = 8,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   moving_avg_filter_if.slave     bus
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = DATA_W + LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);
`ifdef MOVING_AVG_ROUND_EN
   localparam logic [SUM_W-1:0] ROUND_HALF = SUM_W'(1) << (LOG2_DEPTH - 1);
`endif

   logic [DATA_W-1:0]     buffer [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH:0]   fill;
   logic [SUM_W-1:0]      sum;
   logic                  out_valid_q;
   logic [DATA_W-1:0]     out_data_q;
   logic                  window_full_q;

   logic [SUM_W-1:0]      old_ext;
   logic [SUM_W-1:0]      new_sum;
   logic [LOG2_DEPTH:0]   fill_next;
   logic [DATA_W-1:0]     avg_next;
   logic                  accept;

   assign accept = bus.in_valid && !clr;

   // Until the window is full the stale buffer slot is masked to zero,
   // so the memory never needs clearing on reset or clr.
   always_comb begin
      old_ext   = '0;
      fill_next = fill;
      if (fill == FILL_MAX) begin
         old_ext = SUM_W'(buffer[wr_ptr]);
      end else begin
         fill_next = fill + 1'b1;
      end
      new_sum = sum - old_ext + SUM_W'(bus.in_data);
`ifdef MOVING_AVG_ROUND_EN
      avg_next = DATA_W'((new_sum + ROUND_HALF) >> LOG2_DEPTH);
`else
      avg_next = DATA_W'(new_sum >> LOG2_DEPTH);
`endif
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         buffer[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum           <= '0;
         wr_ptr        <= '0;
         fill          <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         window_full_q <= 1'b0;
      end else if (clr) begin
         sum           <= '0;
         wr_ptr        <= '0;
         fill          <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         window_full_q <= 1'b0;
      end else if (bus.in_valid) begin
         sum           <= new_sum;
         wr_ptr        <= wr_ptr + 1'b1;
         fill          <= fill_next;
         out_valid_q   <= 1'b1;
         out_data_q    <= avg_next;
         window_full_q <= (fill_next == FILL_MAX);
      end else begin
         out_valid_q   <= 1'b0;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.window_full = window_full_q;
endmodule
